// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-side memory target for the CPU memory-access stage. It holds a
//   single-ported RAM of 2^ADDR_W 32-bit words with byte-lane writes. It
//   accepts one request at a time over a ce/ack handshake. After a
//   programmable number of wait states it answers with a one-cycle ack,
//   which carries load data or an error flag.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   mem_ce_i    request valid, held until ack
//   mem_we_i    1 = store, 0 = load
//   mem_addr_i  word-aligned byte address
//   mem_sel_i   byte-lane enables, sel[3] -> data[31:24]
//   mem_data_i  store data
//   mem_data_o  load data, valid with mem_ack_o
//   mem_ack_o   one-cycle completion pulse
//   mem_err_o   error qualifier, valid with mem_ack_o
//
// FSM states
//   state | meaning
//   IDLE  | waiting for mem_ce_i; captures the request on acceptance
//   WAIT  | counting wait states; inputs ignored
//   RESP  | ack (and err/data) presented for exactly one cycle
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        mem_err_o
);

  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_data;

  logic capture;
  logic do_access;

  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [3:0]        acc_sel;
  logic [31:0]       acc_data;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_idx;

  logic [31:0] ram [0:(2**ADDR_W)-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (mem_ce_i) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt = RESP;
            do_access = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          do_access = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge itself,
  // before the capture registers hold the request, so use the live inputs.
  always_comb begin
    if (state == IDLE) begin
      acc_we   = mem_we_i;
      acc_addr = mem_addr_i;
      acc_sel  = mem_sel_i;
      acc_data = mem_data_i;
    end else begin
      acc_we   = req_we;
      acc_addr = req_addr;
      acc_sel  = req_sel;
      acc_data = req_data;
    end
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_W+2] != '0);
    acc_idx = acc_addr[ADDR_W+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_we     <= 1'b0;
      req_addr   <= 32'd0;
      req_sel    <= 4'd0;
      req_data   <= 32'd0;
      mem_ack_o  <= 1'b0;
      mem_err_o  <= 1'b0;
      mem_data_o <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        req_we   <= mem_we_i;
        req_addr <= mem_addr_i;
        req_sel  <= mem_sel_i;
        req_data <= mem_data_i;
      end
      mem_ack_o  <= do_access;
      mem_err_o  <= do_access && acc_err;
      mem_data_o <= (do_access && !acc_we && !acc_err) ? ram[acc_idx] : 32'd0;
    end
  end

  // RAM contents survive reset; only the write enable is blocked by it.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) ram[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int WAIT_MAIN = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ce = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
  logic [3:0]  sel = 4'd0;
  logic        ack, err;

  logic        ce0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0, rdata0;
  logic [3:0]  sel0 = 4'd0;
  logic        ack0, err0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(WAIT_MAIN)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(ce), .mem_we_i(we), .mem_addr_i(addr), .mem_sel_i(sel),
    .mem_data_i(wdata), .mem_data_o(rdata), .mem_ack_o(ack), .mem_err_o(err)
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .mem_ce_i(ce0), .mem_we_i(we0), .mem_addr_i(addr0), .mem_sel_i(sel0),
    .mem_data_i(wdata0), .mem_data_o(rdata0), .mem_ack_o(ack0), .mem_err_o(err0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // One request on the main instance; checks latency and the single-cycle ack.
  task automatic do_req(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit churn,
                        output logic [31:0] rd, output logic er);
    int n;
    ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (churn && n == 1) begin
        addr = $urandom; wdata = $urandom; sel = 4'($urandom); we = ~we;
      end
    end while (!ack && n < 10);
    check("latency", n, WAIT_MAIN + 1);
    rd = rdata; er = err;
    ce = 1'b0; we = 1'b0; addr = 32'd0; sel = 4'd0; wdata = 32'd0;
    @(posedge clk); #1;
    check("ack_one_cycle", ack, 1'b0);
    check("data_after_resp", rdata, 32'd0);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vt[15];

  logic [31:0] model [0:15];

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } b2b_t;

  b2b_t        bq[8];
  logic [31:0] rd;
  logic        er;
  int          ack_cnt;

  initial begin
    vt[0]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hA5A5_5A5A, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[3]  = '{1'b1, 32'h0000_0010, 4'h5, 32'h1122_3344, 32'h0, 1'b0};
    vt[4]  = '{1'b0, 32'h0000_0010, 4'h1, 32'h0,         32'hDE22_BE44, 1'b0};
    vt[5]  = '{1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vt[6]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDE22_BE44, 1'b0};
    vt[7]  = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,         32'h0, 1'b1};
    vt[8]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678, 32'h0, 1'b1};
    vt[9]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'hA5A5_5A5A, 1'b0};
    vt[10] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0};
    vt[11] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
    vt[12] = '{1'b0, 32'h8000_0FFC, 4'hF, 32'h0,         32'h0, 1'b1};
    vt[13] = '{1'b1, 32'h0000_0002, 4'hF, 32'h0,         32'h0, 1'b1};
    vt[14] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'hA5A5_5A5A, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", ack, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_data", rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      do_req(vt[i].we, vt[i].addr, vt[i].sel, vt[i].wdata, 1'b0, rd, er);
      check($sformatf("vec%0d_data", i), rd, vt[i].exp_data);
      check($sformatf("vec%0d_err", i), er, vt[i].exp_err);
    end

    // Inputs scrambled during WAIT must not affect the captured request.
    do_req(1'b1, 32'h20, 4'hF, 32'h0BAD_CAFE, 1'b1, rd, er);
    check("churn_store_err", er, 1'b0);
    do_req(1'b0, 32'h20, 4'hF, 32'h0, 1'b1, rd, er);
    check("churn_load_data", rd, 32'h0BAD_CAFE);

    // Reset while in WAIT: request is dropped, RAM is kept.
    ce = 1'b1; we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'h9999_9999;
    @(posedge clk); #1;
    rst = 1'b1; ce = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ack", ack, 1'b0);
    check("rst_mid_err", err, 1'b0);
    check("rst_mid_data", rdata, 32'd0);
    rst = 1'b0;
    ack_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack) ack_cnt++;
    end
    check("rst_no_late_ack", ack_cnt, 0);
    do_req(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd, er);
    check("rst_ram_kept", rd, 32'hDE22_BE44);

    // Randomised traffic over words 0..15 against a word-array model.
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      do_req(1'b1, 32'(i * 4), 4'hF, model[i], 1'b0, rd, er);
      check("prefill_err", er, 1'b0);
    end
    for (int t = 0; t < 150; t++) begin
      int          kind, idx;
      logic [31:0] a, d, exp_d;
      logic [3:0]  s;
      bit          w, exp_e;
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, 15);
      a    = 32'(idx * 4);
      if (kind == 0) a = a + 32'($urandom_range(1, 3));
      if (kind == 1) a = a | (32'd1 << $urandom_range(12, 31));
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom);
      d = $urandom;
      exp_e = (kind <= 1);
      exp_d = 32'd0;
      if (!exp_e) begin
        if (w) model[idx] = (model[idx] & ~lane_mask(s)) | (d & lane_mask(s));
        else   exp_d = model[idx];
      end
      do_req(w, a, s, d, t[0], rd, er);
      check("rand_data", rd, exp_d);
      check("rand_err", er, exp_e);
    end

    // Back-to-back on the zero-wait instance with ce held high.
    for (int i = 0; i < 4; i++) begin
      bq[2*i]   = '{1'b1, 32'(4 * (i + 1)), $urandom};
      bq[2*i+1] = '{1'b0, 32'(4 * (i + 1)), 32'h0};
    end
    ce0 = 1'b1; we0 = bq[0].we; addr0 = bq[0].addr; wdata0 = bq[0].wdata; sel0 = 4'hF;
    for (int k = 0; k < 8; k++) begin
      int n;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!ack0 && n < 6);
      check(k == 0 ? "b2b_first_latency" : "b2b_gap", n, k == 0 ? 1 : 2);
      check("b2b_err", err0, 1'b0);
      check("b2b_data", rdata0, bq[k].we ? 32'd0 : bq[k-1].wdata);
      if (k < 7) begin
        we0 = bq[k+1].we; addr0 = bq[k+1].addr; wdata0 = bq[k+1].wdata;
      end else begin
        ce0 = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("b2b_idle_ack", ack0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory target answering the load/store requests issued by the CPU memory-access stage.
- Single-ported word RAM of 2^ADDR_W words, with byte-lane writes and a programmable wait-state count.
- Accepts one request at a time over a ce/ack handshake and returns read data or an error flag with the ack.
- Sits outside the pipeline on the data side; the memory stage stalls until ack.

Parameters:
- ADDR_W, 10, log2 of RAM depth in 32-bit words (1024 words, 4 KiB).
- WAIT_CYCLES, 1, extra cycles inserted between request acceptance and ack (0..15).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset (rst == `RstEnable).
- mem_ce_i  input  1  request valid; held stable until ack.
- mem_we_i  input  1  1 = store, 0 = load.
- mem_addr_i  input  32  byte address; must be word aligned.
- mem_sel_i  input  4  byte-lane enables; sel[3] = data[31:24] (big-endian lane order), sel[0] = data[7:0].
- mem_data_i  input  32  store data.
- mem_data_o  output  32  load data, valid while mem_ack_o = 1.
- mem_ack_o  output  1  one-cycle completion pulse.
- mem_err_o  output  1  error qualifier, valid only with mem_ack_o.

Behaviour:
- Reset (rst high at an edge):
  - state becomes IDLE; mem_ack_o = 0, mem_err_o = 0, mem_data_o = `ZeroWord.
  - Wait counter = 0; any captured request is discarded.
  - RAM contents are not cleared.
  - Reset has priority over every other event, including mid-WAIT or during the RESP cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - mem_ce_i = 0 -> stay in IDLE.
  - mem_ce_i = 1 -> capture we/addr/sel/data into internal registers. Next state is WAIT with counter = WAIT_CYCLES - 1 if WAIT_CYCLES > 0, else RESP.
- WAIT:
  - Counter decrements each edge; at counter == 0 the next state is RESP.
  - Inputs are ignored; captured values are used.
- Access:
  - Performed at the edge entering RESP, using the captured request.
  - Error if captured addr[1:0] != 0, or if addr[31:ADDR_W+2] != 0.
  - On error: no write, mem_data_o = 0, mem_err_o = 1.
  - Store, no error: write each lane whose sel bit = 1; other lanes are unchanged. mem_data_o = 0.
  - Load, no error: mem_data_o = RAM[addr[ADDR_W+1:2]], full word regardless of sel (the requester extracts bytes).
  - sel = 4'b0000 on a store is legal and writes nothing.
- RESP:
  - mem_ack_o = 1 (and mem_err_o as computed) for exactly one cycle.
  - Next state is always IDLE.
  - mem_data_o returns to 0 and ack/err return to 0 after RESP.
- Latency: acceptance edge E0 -> ack high in the cycle after edge E0 + WAIT_CYCLES. With WAIT_CYCLES = 1, ack is high 2 cycles after ce is first sampled.
- Requester rule: on seeing ack, it drops ce or presents the next request. ce still high in IDLE is a new request, so back-to-back throughput is one request per WAIT_CYCLES + 2 cycles.
- Input changes while in WAIT or RESP have no effect.
- Read-after-write to the same word in consecutive requests returns the written data.

Test Plan:
- Store then load, WAIT_CYCLES = 1: store 0xDEADBEEF to 0x10 with sel = 1111, then load 0x10. Each request gets ack exactly 2 cycles after ce is sampled; the load returns 0xDEADBEEF with err = 0.
- Byte lanes: after the above, store 0x11223344 to 0x10 with sel = 0101 -> subsequent load returns 0xDE22BE44.
- Errors:
  - Load from 0x13 -> ack = 1, err = 1, data = 0.
  - Store to 0x00001000 (ADDR_W = 10) -> ack = 1, err = 1.
  - A following load of 0x0 confirms word 0 is unchanged.
- Back-to-back with ce held high and WAIT_CYCLES = 0: acks occur on alternating cycles, and each load returns the value from the prior store.
- Reset mid-operation: assert rst while in WAIT -> no ack ever appears for that request, outputs are 0 the cycle after reset, and RAM data written earlier is still readable.
- Input churn: change addr/data during WAIT -> the access uses the values captured at acceptance.
